axi4_master_arb: RTL and testbench
==================================

# axi4_master_arb

Single-beat AXI4 master that shares one AXI4 interface among `NUM_REQ` local requesters. Round-robin arbitration picks one request at a time. The block sequences the transaction through AW→W→B for a write or AR→R for a read, then returns the response and read data to the winner. It sits between the design's internal request sources and the `axi4_if` bus that connects to the slave.

## Interface
- `DATA_WIDTH`, 32, address and data width.
- `NUM_REQ`, 2, number of requesters (2..8, because `arid` is 3 bits).
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  NUM_REQ  request per requester; held high until the matching `done_o` bit.
- `op_i`  in  2*NUM_REQ  per-requester opcode: 2'b01 write, 2'b10 read, others illegal.
- `addr_i`  in  NUM_REQ*DATA_WIDTH  per-requester address.
- `wdata_i`  in  NUM_REQ*DATA_WIDTH  per-requester write data.
- `done_o`  out  NUM_REQ  one-cycle completion pulse, one-hot.
- `rdata_o`  out  DATA_WIDTH  read data; valid while `done_o` is high.
- `resp_o`  out  3  response; valid while `done_o` is high.
- AXI master outputs: `awvalid`, `awaddr`[DATA_WIDTH], `wvalid`, `wdata`[DATA_WIDTH], `bready`, `arvalid`, `arid`[3], `araddr`[DATA_WIDTH], `rready`.
- AXI master inputs: `awready`, `wready`, `bvalid`, `bresp`[3], `arready`, `rvalid`, `rid`[3], `rdata`[DATA_WIDTH], `rresp`[3].

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- **IDLE:** `req_i` is sampled at the edge that ends the cycle. If any bit is set:
  - grant via round-robin;
  - latch the winner's op, addr and wdata into registers;
  - go to AW for a write, AR for a read, or DONE for an illegal op.
- **Illegal op:** no bus activity; `resp_o`=3'b010 (SLVERR), `rdata_o`=0.
- **Round-robin:** priority starts at the index after the last grant. The pointer updates only on a grant. Reset value of the pointer is NUM_REQ-1, so requester 0 wins first.
- **AW:** `awvalid`=1, `awaddr`=latched addr. On `awvalid&awready` → W.
- **W:** `wvalid`=1, `wdata`=latched data. On `wvalid&wready` → B.
- **B:** `bready`=1. On `bvalid` capture `bresp` into `resp_o` → DONE.
- **AR:** `arvalid`=1, `araddr`=latched addr, `arid`=granted index. On `arready` → R.
- **R:** `rready`=1. On `rvalid`:
  - capture `rdata` into `rdata_o` and `rresp` into `resp_o`;
  - if `rid`≠`arid`, force `resp_o`=3'b010 (SLVERR);
  - → DONE.
- **DONE:** `done_o[grant]`=1 for exactly one cycle → IDLE.
- **Handshake stability:** once asserted, every valid stays high with its payload stable until its ready is sampled high. There is no timeout and no abort.
- **Held request:** a requester that keeps `req_i` high through the IDLE sample starts a new transaction.
- **Reset:** `rst_i` mid-transaction abandons it at the next edge. No `done_o` is issued.
- **Output reset values:** every AXI output and `done_o`, `rdata_o`, `resp_o` is 0; state is IDLE.

## Timing
- All outputs are registered (decoded from the state register and latched data).
- Zero-wait write: request sampled at edge 0; AW in cycle 1, W in cycle 2, B in cycle 3, `done_o` in cycle 4, IDLE in cycle 5. Earliest next grant is at the end of cycle 5.
- Zero-wait read: AR in cycle 1, R in cycle 2, `done_o` in cycle 3.
- Illegal op: `done_o` in cycle 1.
- Each cycle of deasserted ready/valid adds exactly one cycle to the matching state.
- AW and W are never concurrent. Only one transaction is ever outstanding.

## Structure
- Package `axi4_ctrl_pkg` holds:
  - state enum;
  - op constants OP_WR=2'b01, OP_RD=2'b10;
  - resp constants RESP_OKAY=3'b000, RESP_SLVERR=3'b010.
- Sub-module `axi4_rr_arbiter`: parameter NUM_REQ; inputs `req`, `en`; outputs one-hot `gnt` and `gnt_idx`; owns the priority pointer.
- Top level: FSM, payload latches, AXI drive and response capture.

## Test plan
- **Single write:** req0 writes 0xA5A5_0001 to 0x10, all readies high → awaddr=0x10 in cycle 1, wdata=0xA5A5_0001 in cycle 2, done_o=2'b01 in cycle 4, resp_o=0.
- **Single read with stalls:** req1 reads 0x20; arready is low 3 cycles, then rdata=0xDEAD_BEEF with rid=1 → arvalid is held stable 4 cycles; done_o=2'b10, rdata_o=0xDEAD_BEEF, resp_o=0.
- **Contention:** req_i=2'b11 held for 4 transactions → grants go 0,1,0,1.
- **Illegal and mismatch cases:**
  - op_i=2'b11 → no valid asserted; done_o in cycle 1 with resp_o=3'b010.
  - a read returning rid=5 → resp_o=3'b010.
- **Reset mid-op:** rst_i=1 while in W with wready low → next cycle all outputs are 0 and state is IDLE, with no done_o. After reset, a pending req1 is granted before req0 only if req0 is low.

Source files
------------

// File: rtl/axi4_ctrl_pkg.sv
// Shared types and constants for the single-beat AXI4 arbitrated master.
package axi4_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [1:0] OP_WR       = 2'b01;
    localparam logic [1:0] OP_RD       = 2'b10;
    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

    // First bus phase for a granted opcode; illegal opcodes complete at once.
    function automatic state_t first_state(input logic [1:0] op);
        state_t st;
        case (op)
            OP_WR:   st = S_AW;
            OP_RD:   st = S_AR;
            default: st = S_DONE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// Single-beat AXI4 subset shared by the arbitrated master and its slave.
interface axi4_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  bvalid;
    logic                  bready;
    logic [2:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [2:0]            arid;
    logic [DATA_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [2:0]            rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [2:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready,
        output arvalid, arid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready,
        input  arvalid, arid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rid, rdata, rresp
    );
endinterface

// File: rtl/axi4_rr_arbiter.sv
// Round-robin arbiter; search starts one past the last granted index.
module axi4_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQ-1:0]                        req,
    input  logic                                      en,
    output logic [NUM_REQ-1:0]                        gnt,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_idx
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    int               w_cand;

    // Pick the first requester at or after r_ptr+1, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_cand  = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(r_ptr) + 1 + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && req[IDX_W'(w_cand)]) begin
                w_found                 = 1'b1;
                gnt[IDX_W'(w_cand)]     = 1'b1;
                gnt_idx                 = IDX_W'(w_cand);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Pointer moves only on an actual grant; reset value makes index 0 win first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (en && (|req)) begin
            r_ptr <= gnt_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/axi4_master_arb.sv
// Shares one single-beat AXI4 master port among NUM_REQ local requesters,
// one transaction at a time, sequencing AW->W->B or AR->R.
module axi4_master_arb
    import axi4_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [2*NUM_REQ-1:0]          op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [2:0]                    resp_o,
    axi4_if.master                        bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [2:0]            r_resp;

    logic                  w_arb_en;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [1:0]            w_op_sel;
    logic [DATA_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_wdata_sel;
    logic                  w_grant;

    assign w_arb_en = (r_state == S_IDLE);
    assign w_grant  = w_arb_en && (|req_i);

    axi4_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req_i),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // One-hot mux of the winner's opcode and payload.
    always_comb begin
        w_op_sel    = 2'b00;
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op_sel    = w_op_sel    | op_i[2*i +: 2];
                w_addr_sel  = w_addr_sel  | addr_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_wdata_sel = w_wdata_sel | wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_op_sel = w_op_sel;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; each phase waits for its handshake with no timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (|req_i) w_next_state = first_state(w_op_sel);
                else        w_next_state = S_IDLE;
            end
            S_AW: begin
                if (bus.awready) w_next_state = S_W;
                else             w_next_state = S_AW;
            end
            S_W: begin
                if (bus.wready) w_next_state = S_B;
                else            w_next_state = S_W;
            end
            S_B: begin
                if (bus.bvalid) w_next_state = S_DONE;
                else            w_next_state = S_B;
            end
            S_AR: begin
                if (bus.arready) w_next_state = S_R;
                else             w_next_state = S_AR;
            end
            S_R: begin
                if (bus.rvalid) w_next_state = S_DONE;
                else            w_next_state = S_R;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Payload latch at grant and response capture from B or R.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_resp  <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_idx   <= w_gnt_idx;
                        r_gnt   <= w_gnt;
                        r_addr  <= w_addr_sel;
                        r_wdata <= w_wdata_sel;
                        r_rdata <= '0;
                        r_resp  <= (first_state(w_op_sel) == S_DONE) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                S_B: begin
                    if (bus.bvalid) r_resp <= bus.bresp;
                    else            r_resp <= r_resp;
                end
                S_R: begin
                    if (bus.rvalid) begin
                        r_rdata <= bus.rdata;
                        // A response tagged for another requester is not trusted.
                        r_resp  <= (bus.rid == 3'(r_idx)) ? bus.rresp : RESP_SLVERR;
                    end else begin
                        r_resp <= r_resp;
                    end
                end
                default: r_resp <= r_resp;
            endcase
        end
    end

    assign bus.awvalid = (r_state == S_AW);
    assign bus.awaddr  = (r_state == S_AW) ? r_addr : '0;
    assign bus.wvalid  = (r_state == S_W);
    assign bus.wdata   = (r_state == S_W) ? r_wdata : '0;
    assign bus.bready  = (r_state == S_B);
    assign bus.arvalid = (r_state == S_AR);
    assign bus.araddr  = (r_state == S_AR) ? r_addr : '0;
    assign bus.arid    = (r_state == S_AR) ? 3'(r_idx) : 3'b000;
    assign bus.rready  = (r_state == S_R);
    assign done_o      = (r_state == S_DONE) ? r_gnt : '0;
    assign rdata_o     = r_rdata;
    assign resp_o      = r_resp;

endmodule

// File: tb/tb_axi4_master_arb.sv
// Bench for axi4_master_arb: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_axi4_master_arb;
    import axi4_ctrl_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int P_NONE = 0, P_AW = 1, P_W = 2, P_B = 3, P_AR = 4, P_R = 5, P_DN = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [2*N-1:0]  op = '0;
    logic [N*DW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata_o;
    logic [2:0]      resp_o;

    axi4_if #(.DATA_WIDTH(DW)) bus ();

    axi4_master_arb #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .op_i    (op),
        .addr_i  (addr),
        .wdata_i (wdata),
        .done_o  (done),
        .rdata_o (rdata_o),
        .resp_o  (resp_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: remaining phases of the one open transaction.
    int            steps[$];
    int            m_ptr = N - 1;
    int            m_idx = 0;
    logic [1:0]    m_op = 2'b00;
    logic [DW-1:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [2:0]    m_resp = 3'b000;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            steps.delete();
            m_ptr  = N - 1;
            m_resp = 3'b000;
            m_rdata = '0;
        end else if (steps.size() == 0) begin
            if (req != '0) begin
                int win;
                win = 0;
                for (int k = 0; k < N; k++) begin
                    if (req[(m_ptr + 1 + k) % N]) begin
                        win = (m_ptr + 1 + k) % N;
                        break;
                    end
                end
                m_ptr   = win;
                m_idx   = win;
                m_op    = op[2*win +: 2];
                m_addr  = addr[win*DW +: DW];
                m_wdata = wdata[win*DW +: DW];
                m_rdata = '0;
                if (m_op == OP_WR) begin
                    steps.push_back(P_AW); steps.push_back(P_W);
                    steps.push_back(P_B);  steps.push_back(P_DN);
                    m_resp = RESP_OKAY;
                end else if (m_op == OP_RD) begin
                    steps.push_back(P_AR); steps.push_back(P_R); steps.push_back(P_DN);
                    m_resp = RESP_OKAY;
                end else begin
                    steps.push_back(P_DN);
                    m_resp = RESP_SLVERR;
                end
            end
        end else begin
            case (steps[0])
                P_AW: if (bus.awready) void'(steps.pop_front());
                P_W:  if (bus.wready)  void'(steps.pop_front());
                P_B:  if (bus.bvalid) begin m_resp = bus.bresp; void'(steps.pop_front()); end
                P_AR: if (bus.arready) void'(steps.pop_front());
                P_R:  if (bus.rvalid) begin
                          m_rdata = bus.rdata;
                          m_resp  = (bus.rid == 3'(m_idx)) ? bus.rresp : RESP_SLVERR;
                          void'(steps.pop_front());
                      end
                default: void'(steps.pop_front());
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin : cmp
        int f;
        @(negedge clk);
        if (cmp_en) begin
            f = (steps.size() != 0) ? steps[0] : P_NONE;
            chk("m_awvalid", bus.awvalid, (f == P_AW));
            chk("m_wvalid",  bus.wvalid,  (f == P_W));
            chk("m_bready",  bus.bready,  (f == P_B));
            chk("m_arvalid", bus.arvalid, (f == P_AR));
            chk("m_rready",  bus.rready,  (f == P_R));
            chk("m_done",    done, (f == P_DN) ? (64'd1 << m_idx) : 64'd0);
            if (f == P_AW) chk("m_awaddr", bus.awaddr, m_addr);
            if (f == P_W)  chk("m_wdata",  bus.wdata,  m_wdata);
            if (f == P_AR) begin
                chk("m_araddr", bus.araddr, m_addr);
                chk("m_arid",   bus.arid,   m_idx);
            end
            if (f == P_DN) begin
                chk("m_resp", resp_o, m_resp);
                if (m_op != OP_WR) chk("m_rdata", rdata_o, m_rdata);
            end
        end
    end

    task automatic wait_done(input int max, output logic [N-1:0] d);
        d = '0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (done != '0) begin
                d = done;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: got no done_o within %0d cycles at %0t", max, $time);
    endtask

    task automatic new_payload(input int i);
        int r;
        r = $urandom_range(0, 9);
        op[2*i +: 2]    = (r < 4) ? OP_WR : (r < 8) ? OP_RD : (r == 8) ? 2'b00 : 2'b11;
        addr[i*DW +: DW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
    endtask

    logic [N-1:0] d;
    logic [2:0]   sl_id = 3'd0;

    initial begin
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 3'b000;
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rid = 3'd0;
        bus.rdata = 32'h0; bus.rresp = 3'b000;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_arvalid", bus.arvalid, 1'b0);
        chk("rst_done",    done, 2'b00);
        chk("rst_resp",    resp_o, 3'b000);
        chk("rst_rdata",   rdata_o, 32'h0);

        // Single zero-wait write from requester 0.
        rst = 1'b0;
        op[1:0] = OP_WR; addr[31:0] = 32'h10; wdata[31:0] = 32'hA5A5_0001; req = 2'b01;
        @(negedge clk); chk("wr_awvalid", bus.awvalid, 1'b1); chk("wr_awaddr", bus.awaddr, 32'h10);
        @(negedge clk); chk("wr_wvalid", bus.wvalid, 1'b1); chk("wr_wdata", bus.wdata, 32'hA5A5_0001);
        @(negedge clk); chk("wr_bready", bus.bready, 1'b1);
        @(negedge clk); chk("wr_done", done, 2'b01); chk("wr_resp", resp_o, 3'b000);
        req = 2'b00;
        @(negedge clk); chk("wr_idle_done", done, 2'b00);

        // Read from requester 1 with arready stalled three cycles.
        op[3:2] = OP_RD; addr[63:32] = 32'h20; req = 2'b10;
        bus.arready = 1'b0; bus.rdata = 32'hDEAD_BEEF; bus.rid = 3'd1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("rd_arvalid", bus.arvalid, 1'b1);
            chk("rd_araddr", bus.araddr, 32'h20);
            chk("rd_arid", bus.arid, 3'd1);
            if (c == 4) bus.arready = 1'b1;
        end
        @(negedge clk); chk("rd_rready", bus.rready, 1'b1);
        @(negedge clk); chk("rd_done", done, 2'b10);
        chk("rd_rdata", rdata_o, 32'hDEAD_BEEF); chk("rd_resp", resp_o, 3'b000);
        req = 2'b00;

        // Contention: both held for four transactions.
        op = {OP_WR, OP_WR}; addr = {32'h200, 32'h100}; req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_done(20, d);
            chk("rr_order", d, (t % 2 == 0) ? 2'b01 : 2'b10);
            if (t == 3) req = 2'b00;
        end
        @(negedge clk);

        // Illegal opcode completes in cycle 1 with no bus activity.
        op[1:0] = 2'b11; req = 2'b01;
        @(negedge clk);
        chk("ill_done", done, 2'b01); chk("ill_resp", resp_o, RESP_SLVERR);
        chk("ill_rdata", rdata_o, 32'h0);
        chk("ill_valid", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b000);
        req = 2'b00;
        @(negedge clk);

        // Read answered with a foreign rid.
        op[3:2] = OP_RD; bus.rid = 3'd5; bus.rresp = 3'b000; req = 2'b10;
        wait_done(10, d);
        chk("rid_done", d, 2'b10); chk("rid_resp", resp_o, RESP_SLVERR);
        req = 2'b00;
        @(negedge clk);

        // Reset while W is stalled, then requester 1 alone is served.
        op[1:0] = OP_WR; req = 2'b01; bus.wready = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("rst_mid_wvalid", bus.wvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outs", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
        chk("rstmid_done", done, 2'b00); chk("rstmid_resp", resp_o, 3'b000);
        chk("rstmid_rdata", rdata_o, 32'h0);
        rst = 1'b0; bus.wready = 1'b1; bus.rid = 3'd1; op[3:2] = OP_RD; req = 2'b10;
        wait_done(10, d);
        chk("rstmid_next", d, 2'b10); chk("rstmid_next_resp", resp_o, 3'b000);
        req = 2'b00;
        @(negedge clk);

        // Random traffic with random stalls, occasional bad rid and resets.
        repeat (4000) begin
            @(negedge clk);
            if (bus.arvalid) sl_id = bus.arid;
            bus.awready = ($urandom_range(0, 3) != 0);
            bus.wready  = ($urandom_range(0, 3) != 0);
            bus.bvalid  = ($urandom_range(0, 2) != 0);
            bus.bresp   = 3'($urandom);
            bus.arready = ($urandom_range(0, 3) != 0);
            bus.rvalid  = ($urandom_range(0, 2) != 0);
            bus.rdata   = $urandom;
            bus.rresp   = 3'($urandom);
            bus.rid     = ($urandom_range(0, 7) == 0) ? 3'($urandom) : sl_id;
            rst         = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && done[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else new_payload(i);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    new_payload(i);
                    req[i] = 1'b1;
                end
            end
        end
        rst = 1'b0; req = '0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
        bus.arready = 1'b1; bus.rvalid = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
